spi_cfg_sequencer: RTL
======================

Name: spi_cfg_sequencer

Overview:
Master-side controller that drives the chip's SPI configuration port (sclk/ncs/copi) to issue register writes to the SPI register bank.
- Queues write requests (7-bit address, 8-bit data) from on-chip logic in a small FIFO.
- Serialises each request as one 16-bit write frame, with a programmable sclk rate and inter-frame gap.
- Rejects out-of-range addresses with a sticky error flag.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255.
GAP_CYCLES, 8, minimum ncs-high cycles between consecutive frames; legal range 1..255.
FIFO_DEPTH, 4, request queue entries; must be a power of 2, at least 2.
MAX_ADDRESS, 4, highest legal register address.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  write request present
req_ready  output  1  request accepted this cycle when req_valid and req_ready are both 1
req_addr  input  7  target register address
req_data  input  8  write data
clear_err  input  1  one-cycle pulse that clears err_addr
sclk  output  1  SPI clock, mode 0, idles low
ncs  output  1  SPI chip select, active low
copi  output  1  SPI serial data out
busy  output  1  high while a frame is in progress or the FIFO is non-empty
err_addr  output  1  sticky flag: a request was dropped because its address was out of range
frames_sent  output  8  count of completed frames, wraps modulo 256

Behaviour:
- Reset values (async on rst_n=0, all registered): ncs=1, sclk=0, copi=0, busy=0, err_addr=0, frames_sent=0, FIFO empty, state=IDLE. Reset mid-frame aborts the frame and raises ncs immediately.
- Request handshake:
  - req_ready = FIFO not full; combinational from FIFO count only.
  - An accepted request with req_addr <= MAX_ADDRESS is pushed to the FIFO.
  - An accepted request with req_addr > MAX_ADDRESS is consumed but not pushed, and err_addr is set.
  - If err_addr set and clear_err occur in the same cycle, the set wins.
- Push and pop in the same cycle are both performed; the count is unchanged.
- Frame format: 16 bits, MSB first, as {1'b1 (write), addr[6:0], data[7:0]}.
  - copi changes only while sclk is low; the peripheral samples on sclk rising edges.
- State machine:
  - IDLE: ncs=1, sclk=0. If the FIFO is non-empty, pop the head, load the shift register, drive ncs=0 and copi=bit15, go to SETUP.
  - SETUP: hold for CLK_DIV cycles, then sclk=1 (first rising edge), go to SHIFT.
  - SHIFT: toggle sclk every CLK_DIV cycles.
    - On each falling edge, shift the next bit onto copi.
    - After the 16th high phase completes, drive sclk=0 and go to HOLD.
  - HOLD: sclk low for CLK_DIV cycles, then ncs=1, increment frames_sent, go to GAP.
  - GAP: ncs=1 for GAP_CYCLES cycles, then go to IDLE.
- Frame timing:
  - ncs is low for exactly 33*CLK_DIV cycles (132 cycles at the default).
  - Exactly 16 sclk rising edges occur per frame.
  - Start-to-start spacing for back-to-back frames is 33*CLK_DIV + GAP_CYCLES + 1 cycles.
- copi returns to 0 in IDLE and GAP.
- busy = (state != IDLE) or (FIFO count != 0).
- frames_sent wraps from 255 to 0 with no flag.
- Requests accepted mid-frame never disturb the frame in flight; FIFO order is strictly preserved.
- Parameter legality is not checked in RTL; the bench uses legal values only.

Test Plan:
- Single write addr=0x02, data=0xA5, defaults: ncs is low 132 cycles; 16 rising edges sample bits 1,0000010,10100101; frames_sent=1; busy drops after the 8-cycle gap.
- Burst of 5 requests (addr 0..4, data 0x11..0x55) with req_valid held high: req_ready deasserts when 4 entries are queued; all 5 frames go out in order; frame start spacing is 141 cycles; final frames_sent=5.
- Out-of-range address: req_addr=0x05, then 0x7F, then a valid 0x00/0xFF. Required: no frame for either bad address; err_addr=1 stays high; exactly one frame carrying 0x00/0xFF. Then a clear_err pulse gives err_addr=0; clear_err in the same cycle as a new bad request leaves err_addr=1.
- Reset mid-frame: assert rst_n=0 at the 8th sclk rising edge with 2 requests queued. Required: ncs=1, sclk=0, busy=0 in the same cycle; after release, no frames are sent and frames_sent=0.
- Parameter sweep CLK_DIV=2, GAP_CYCLES=1: a single write shows ncs low 66 cycles and sclk high/low phases of 2 cycles; copi never changes while sclk=1.
- Wrap: issue 256 valid frames, then check frames_sent=0; issue one more, then check frames_sent=1.

Source files
------------

// File: rtl/spi_cfg_sequencer_if.sv
// Request handshake between on-chip logic (master) and the SPI configuration
// sequencer (slave): one 7-bit address / 8-bit data write per valid&ready cycle.
interface spi_cfg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/spi_cfg_sequencer.sv
// SPI mode-0 register-write sequencer: queues write requests in a FIFO and
// serialises each as a 16-bit {1'b1, addr, data} frame, dropping bad addresses.
module spi_cfg_sequencer #(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_ADDRESS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_cfg_sequencer_if.slave        req_if,
  input  logic                      i_clear_err,
  output logic                      o_sclk,
  output logic                      o_ncs,
  output logic                      o_copi,
  output logic                      o_busy,
  output logic                      o_err_addr,
  output logic [7:0]                o_frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [6:0]    MAX_A    = 7'(MAX_ADDRESS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [14:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [7:0]    r_cnt;
  logic [3:0]    r_bitCnt;
  logic [15:0]   r_shift;
  logic          r_sclk;
  logic          r_ncs;
  logic          r_copi;
  logic [7:0]    r_frames;

  logic          w_accept;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_cnt;
  logic [3:0]    w_bitCnt;
  logic [15:0]   w_shift;
  logic          w_sclk;
  logic          w_ncs;
  logic          w_copi;
  logic [7:0]    w_frames;

  assign req_if.req_ready = (r_count != FULL);
  assign w_accept = req_if.req_valid && req_if.req_ready;
  assign w_bad    = w_accept && (req_if.req_addr > MAX_A);
  assign w_push   = w_accept && !w_bad;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {req_if.req_addr, req_if.req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A bad request landing in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else if (i_clear_err) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_sclk   <= 1'b0;
      r_ncs    <= 1'b1;
      r_copi   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cnt;
      r_bitCnt <= w_bitCnt;
      r_shift  <= w_shift;
      r_sclk   <= w_sclk;
      r_ncs    <= w_ncs;
      r_copi   <= w_copi;
      r_frames <= w_frames;
    end
  end

  // r_bitCnt counts completed sclk high phases; copi advances on each falling edge.
  always_comb begin
    w_stateNext = r_state;
    w_cnt       = r_cnt;
    w_bitCnt    = r_bitCnt;
    w_shift     = r_shift;
    w_sclk      = r_sclk;
    w_ncs       = r_ncs;
    w_copi      = r_copi;
    w_frames    = r_frames;
    case (r_state)
      S_IDLE: begin
        w_ncs  = 1'b1;
        w_sclk = 1'b0;
        w_copi = 1'b0;
        w_cnt  = '0;
        if (w_pop) begin
          w_shift     = {1'b1, r_mem[r_rdPtr]};
          w_bitCnt    = '0;
          w_ncs       = 1'b0;
          w_copi      = 1'b1;
          w_stateNext = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt       = '0;
          w_sclk      = 1'b1;
          w_stateNext = S_SHIFT;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt = '0;
          if (r_sclk) begin
            w_sclk = 1'b0;
            if (r_bitCnt == 4'd15) begin
              w_stateNext = S_HOLD;
            end else begin
              w_shift  = r_shift << 1;
              w_copi   = r_shift[14];
              w_bitCnt = r_bitCnt + 4'd1;
            end
          end else begin
            w_sclk = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt       = '0;
          w_ncs       = 1'b1;
          w_copi      = 1'b0;
          w_frames    = r_frames + 8'd1;
          w_stateNext = S_GAP;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_GAP: begin
        w_copi = 1'b0;
        if (r_cnt == GAP_LAST) begin
          w_cnt       = '0;
          w_stateNext = S_IDLE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign o_sclk        = r_sclk;
  assign o_ncs         = r_ncs;
  assign o_copi        = r_copi;
  assign o_busy        = (r_state != S_IDLE) || (r_count != '0);
  assign o_err_addr    = r_err;
  assign o_frames_sent = r_frames;

endmodule
